memory_bus_responder: RTL and testbench
=======================================

MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for mem_ack before aborting an access.
REQ-002 The block SHALL expose parameter IDLE_RDATA, default 8'hFF, meaning the value returned to the CPU on a timed-out read.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cpu_valid, input, 1 bit: the CPU datapath presents an access this cycle.
REQ-006 The block SHALL have port cpu_write, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port cpu_addr_lo, input, 8 bits: the address-bus-low output of the datapath.
REQ-008 The block SHALL have port cpu_addr_hi, input, 8 bits: the address-bus-high output of the datapath.
REQ-009 The block SHALL have port cpu_wdata, input, 8 bits: the external data-bus write value from the datapath.
REQ-010 The block SHALL have port cpu_rdata, output, 8 bits: the external data-bus read value returned to the datapath.
REQ-011 The block SHALL have port cpu_ready, output, 1 bit: a one-cycle completion strobe for the accepted access.
REQ-012 The block SHALL have memory-side ports as follows.
- mem_req, output, 1 bit: request.
- mem_we, output, 1 bit: write enable.
- mem_addr, output, 16 bits: {addr_hi, addr_lo}.
- mem_wdata, output, 8 bits: write data.
- mem_ack, input, 1 bit: acknowledge.
- mem_rdata, input, 8 bits: read data.
REQ-013 The block SHALL have port bus_error, output, 1 bit: sticky flag set when any access times out.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 In IDLE with cpu_valid=1, the block SHALL capture cpu_write, {cpu_addr_hi, cpu_addr_lo} and cpu_wdata into registers, then enter WAIT.
REQ-016 In IDLE with cpu_valid=0, the block SHALL remain in IDLE.
REQ-017 In WAIT, mem_req SHALL be 1, with mem_we, mem_addr and mem_wdata driven from the captured registers; these outputs SHALL be stable for the entire WAIT period.
REQ-018 In WAIT with mem_ack=1, the block SHALL latch mem_rdata into cpu_rdata on a read, leave cpu_rdata unchanged on a write, and enter RESP.
REQ-019 In WAIT, a wait counter SHALL increment each cycle while mem_ack=0.
REQ-020 When the wait counter reaches TIMEOUT_CYCLES with mem_ack still 0, the block SHALL drop mem_req, set bus_error, load IDLE_RDATA into cpu_rdata on a read, and enter RESP.
REQ-021 If mem_ack=1 arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack SHALL win: the access completes normally and bus_error is not set.
REQ-022 In RESP, cpu_ready SHALL be 1 for exactly one cycle and mem_req SHALL be 0; the next state SHALL be IDLE unconditionally.
REQ-023 cpu_valid SHALL be ignored in WAIT and RESP; the CPU holds its request until it sees cpu_ready.
REQ-024 The wait counter SHALL clear on entry to WAIT, and it SHALL NOT wrap within an access.
REQ-025 Minimum latency SHALL be 2 cycles from cpu_valid sampled in IDLE to cpu_ready (ack in the first WAIT cycle); back-to-back accesses SHALL complete at most one per 3 cycles.
REQ-026 mem_ack received in IDLE or RESP SHALL be ignored and SHALL have no effect on state or outputs.
REQ-027 cpu_rdata SHALL hold its last value until the next read completes.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL go to IDLE and drive outputs as follows.
- mem_req=0, mem_we=0
- mem_addr=16'h0000, mem_wdata=8'h00
- cpu_rdata=8'h00, cpu_ready=0
- bus_error=0, counter=0
REQ-029 If rst=1 occurs during WAIT, mem_req SHALL be 0 from the next cycle, and no cpu_ready SHALL be issued for the aborted access.
REQ-030 Only rst SHALL clear bus_error.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the ADDR_W=16 and DATA_W=8 constants, and the default TIMEOUT_CYCLES.
REQ-032 The wait counter with terminal-count detect SHALL be a sub-module, bus_timeout_counter, with ports clear, enable and expired; the FSM and datapath registers SHALL stay in memory_bus_responder.

Verification
REQ-033 The bench SHALL cover these directed scenarios.
- Read, immediate ack: cpu_valid=1, write=0, addr_hi=8'h12, addr_lo=8'h34; mem_ack=1 in first WAIT cycle with mem_rdata=8'hA5. Required: mem_addr=16'h1234, cpu_rdata=8'hA5, cpu_ready high exactly 2 cycles after accept.
- Write, 3 wait states: write=1, addr=16'hFFFA, cpu_wdata=8'h3C; ack after 3 cycles. Required: mem_we=1, mem_wdata=8'h3C stable throughout WAIT, cpu_rdata unchanged, one cpu_ready pulse.
- Timeout read: TIMEOUT_CYCLES=4, mem_ack never asserted. Required: mem_req drops after 4 cycles, cpu_rdata=8'hFF, bus_error=1 and still 1 after the next successful access.
- Ack at timeout boundary: mem_ack=1 exactly on the expiry cycle with mem_rdata=8'h5A. Required: cpu_rdata=8'h5A, bus_error remains 0.
- Reset mid-WAIT: rst=1 for one cycle during WAIT. Required: all outputs at their reset values, no cpu_ready pulse, and the next access completes normally.
- Stray ack and back-to-back: mem_ack pulsed in IDLE, then two consecutive reads. Required: no state change from the stray ack, and the cpu_ready pulses are 3 cycles apart.

Source files
------------

// File: rtl/memory_bus_responder_pkg.sv
// Shared types and constants for the memory bus responder slice.
package memory_bus_responder_pkg;

  localparam int unsigned ADDR_W                 = 16;
  localparam int unsigned DATA_W                 = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Captured CPU access, driven as-is onto the memory side while waiting.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/memory_bus_responder_timeout.sv
// bus_timeout_counter: counts wait cycles of one access and flags expiry.
//   clk, rst : clock and synchronous active-high reset
//   clear    : hold the count at zero (asserted whenever no access is waiting)
//   enable   : advance the count by one this cycle
//   expired  : registered; high once TIMEOUT_CYCLES wait cycles have been used
module bus_timeout_counter
  import memory_bus_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Index of the last permitted wait cycle; a zero timeout behaves as one.
  localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

  logic [CNT_W-1:0] count;

  // Saturating count; expired is precomputed so it is valid in the cycle
  // the count sits on LAST.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      expired <= (LAST == 0);
    end else if (enable && !expired) begin
      count   <= count + CNT_W'(1);
      expired <= (count == CNT_W'(LAST - 1));
    end
  end

endmodule

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: turns single-cycle CPU access requests into a
// req/ack handshake on the memory side, with a wait-cycle timeout.
//   cpu_valid/cpu_write/cpu_addr_hi/cpu_addr_lo/cpu_wdata : CPU access in
//   cpu_rdata, cpu_ready                                   : CPU response
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata   : memory handshake
//   bus_error                                              : sticky timeout flag
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0]  IDLE_RDATA     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_addr_lo,
  input  logic [7:0]        cpu_addr_hi,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_error
);

  state_t   state;
  mem_cmd_t cmd_q;
  logic     expired;
  logic     cnt_clear;
  logic     cnt_enable;

  // Counter restarts from zero on every entry to WAIT and only runs there.
  assign cnt_clear  = (state != WAIT);
  assign cnt_enable = (state == WAIT) && !mem_ack;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  // Memory-side command comes straight from the capture register, so it is
  // stable for the whole wait period regardless of the CPU inputs.
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // Responder FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      mem_req   <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      bus_error <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            cmd_q.we    <= cpu_write;
            cmd_q.addr  <= {cpu_addr_hi, cpu_addr_lo};
            cmd_q.wdata <= cpu_wdata;
            mem_req     <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // An ack on the expiry cycle takes priority over the timeout.
          if (mem_ack) begin
            if (!cmd_q.we) begin
              cpu_rdata <= mem_rdata;
            end
            mem_req   <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            if (!cmd_q.we) begin
              cpu_rdata <= IDLE_RDATA;
            end
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_responder.sv
// Self-checking bench for memory_bus_responder: directed scenarios plus
// randomized accesses against a transaction-level model.
module tb_memory_bus_responder;

  localparam int unsigned TMO     = 4;
  localparam logic [7:0]  IDLE_RD = 8'hFF;

  logic        tb_clk;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_write;
  logic [7:0]  cpu_addr_lo;
  logic [7:0]  cpu_addr_hi;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_error;

  memory_bus_responder #(
    .TIMEOUT_CYCLES (TMO),
    .IDLE_RDATA     (IDLE_RD)
  ) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .cpu_valid   (cpu_valid),
    .cpu_write   (cpu_write),
    .cpu_addr_lo (cpu_addr_lo),
    .cpu_addr_hi (cpu_addr_hi),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .bus_error   (bus_error)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Model expectations for the current cycle.
  logic        exp_req, exp_ready, exp_we, exp_err;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata, exp_rdata;
  logic        chk_bus = 1'b0;
  logic        chk_en  = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_ready = 0;
  int ready_cyc = 0;
  int acc_cyc = 0;
  int req_cycles = 0;
  logic [15:0] last_addr = 16'h0;
  logic        last_we = 1'b0;
  logic [7:0]  last_wdata = 8'h0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge tb_clk) begin
    if (chk_en) begin
      chk("cpu_ready", 16'(cpu_ready), 16'(exp_ready));
      chk("mem_req",   16'(mem_req),   16'(exp_req));
      chk("cpu_rdata", 16'(cpu_rdata), 16'(exp_rdata));
      chk("bus_error", 16'(bus_error), 16'(exp_err));
      if (chk_bus) begin
        chk("mem_we",    16'(mem_we),    16'(exp_we));
        chk("mem_addr",  mem_addr,       exp_addr);
        chk("mem_wdata", 16'(mem_wdata), 16'(exp_wdata));
      end
      if (cpu_ready === 1'b1) begin
        n_ready++;
        ready_cyc = cyc;
      end
      if (mem_req === 1'b1) begin
        req_cycles++;
        last_addr  = mem_addr;
        last_we    = mem_we;
        last_wdata = mem_wdata;
      end
    end
  end

  task automatic next_cycle();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_req = 1'b0; exp_ready = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
    exp_addr = 16'h0; exp_wdata = 8'h0; exp_rdata = 8'h0;
    chk_bus = 1'b1;
  endtask

  // One access issued from an IDLE cycle. d = WAIT cycles before ack
  // (d >= TMO means no ack). Returns in the IDLE cycle after RESP.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] wd,
                           input int d, input logic [7:0] rd);
    int   n;
    logic to;
    to = (d >= int'(TMO));
    n  = to ? int'(TMO) : d + 1;
    cpu_valid = 1'b1; cpu_write = w;
    cpu_addr_hi = a[15:8]; cpu_addr_lo = a[7:0]; cpu_wdata = wd;
    for (int c = 0; c < n; c++) begin
      next_cycle();
      if (c == 0) acc_cyc = cyc;
      exp_req = 1'b1; exp_ready = 1'b0; chk_bus = 1'b1;
      exp_we = w; exp_addr = a; exp_wdata = wd;
      // CPU-side inputs are don't-care while waiting.
      cpu_valid = 1'($urandom); cpu_write = 1'($urandom);
      cpu_addr_hi = 8'($urandom); cpu_addr_lo = 8'($urandom); cpu_wdata = 8'($urandom);
      mem_ack   = (!to && c == d);
      mem_rdata = (c == d) ? rd : 8'($urandom);
    end
    next_cycle();
    exp_req = 1'b0; exp_ready = 1'b1; chk_bus = 1'b0;
    if (!w) exp_rdata = to ? IDLE_RD : rd;
    if (to) exp_err = 1'b1;
    cpu_valid = 1'($urandom); mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
    next_cycle();
    exp_ready = 1'b0;
    cpu_valid = 1'b0; mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      cpu_valid = 1'b0; mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
      next_cycle();
    end
    cpu_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nr0;
    int r1;
    rst = 1'b1; cpu_valid = 1'b0; cpu_write = 1'b0;
    cpu_addr_hi = 8'h0; cpu_addr_lo = 8'h0; cpu_wdata = 8'h0;
    mem_ack = 1'b0; mem_rdata = 8'h0;

    // Reset state.
    next_cycle();
    set_reset_exp();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset mem_req",   16'(mem_req),   16'h0);
    chk("reset cpu_rdata", 16'(cpu_rdata), 16'h0);
    chk("reset bus_error", 16'(bus_error), 16'h0);
    chk("reset mem_addr",  mem_addr,       16'h0000);
    next_cycle();
    chk_bus = 1'b0;

    // Read, immediate ack.
    req_cycles = 0;
    do_access(1'b0, 16'h1234, 8'h00, 0, 8'hA5);
    chk("rd_imm rdata",   16'(cpu_rdata), 16'h00A5);
    chk("rd_imm addr",    last_addr, 16'h1234);
    chk("rd_imm latency", 16'(ready_cyc + 1 - acc_cyc), 16'd2);
    chk("rd_imm req cyc", 16'(req_cycles), 16'd1);

    // Write, 3 wait states.
    nr0 = n_ready; req_cycles = 0;
    do_access(1'b1, 16'hFFFA, 8'h3C, 3, 8'h77);
    chk("wr rdata kept",  16'(cpu_rdata), 16'h00A5);
    chk("wr ready count", 16'(n_ready - nr0), 16'd1);
    chk("wr we",          16'(last_we), 16'h1);
    chk("wr wdata",       16'(last_wdata), 16'h003C);
    chk("wr req cyc",     16'(req_cycles), 16'd4);

    // Ack on the expiry cycle wins.
    do_access(1'b0, 16'h0100, 8'h00, int'(TMO) - 1, 8'h5A);
    chk("bound rdata", 16'(cpu_rdata), 16'h005A);
    chk("bound err",   16'(bus_error), 16'h0);

    // Timeout read, then a successful access keeps the sticky error.
    req_cycles = 0;
    do_access(1'b0, 16'h2222, 8'h00, 100, 8'h00);
    chk("tmo req cyc", 16'(req_cycles), 16'd4);
    chk("tmo rdata",   16'(cpu_rdata), 16'h00FF);
    chk("tmo err",     16'(bus_error), 16'h1);
    do_access(1'b0, 16'h3333, 8'h00, 1, 8'h42);
    chk("post tmo rdata", 16'(cpu_rdata), 16'h0042);
    chk("post tmo err",   16'(bus_error), 16'h1);

    // Reset in the middle of WAIT.
    nr0 = n_ready;
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr_hi = 8'h44; cpu_addr_lo = 8'h44;
    cpu_wdata = 8'h99; mem_ack = 1'b0;
    next_cycle();
    exp_req = 1'b1; exp_ready = 1'b0; chk_bus = 1'b1;
    exp_we = 1'b0; exp_addr = 16'h4444; exp_wdata = 8'h99;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    set_reset_exp();
    rst = 1'b0; cpu_valid = 1'b0;
    chk("rst wait req",   16'(mem_req),   16'h0);
    chk("rst wait err",   16'(bus_error), 16'h0);
    chk("rst wait rdata", 16'(cpu_rdata), 16'h0);
    next_cycle();
    chk_bus = 1'b0;
    idle_cycles(3);
    chk("rst no ready", 16'(n_ready - nr0), 16'd0);
    do_access(1'b1, 16'h5555, 8'hC3, 2, 8'h00);
    chk("rst next ready", 16'(n_ready - nr0), 16'd1);
    chk("rst next wdata", 16'(last_wdata), 16'h00C3);

    // Stray ack in IDLE, then back-to-back reads.
    cpu_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    next_cycle();
    mem_ack = 1'b0;
    chk("stray rdata", 16'(cpu_rdata), 16'h0);
    chk("stray req",   16'(mem_req),   16'h0);
    chk("stray ready", 16'(cpu_ready), 16'h0);
    do_access(1'b0, 16'h0001, 8'h00, 0, 8'h11);
    r1 = ready_cyc;
    do_access(1'b0, 16'h0002, 8'h00, 0, 8'h22);
    chk("b2b gap",   16'(ready_cyc - r1), 16'd3);
    chk("b2b rdata", 16'(cpu_rdata), 16'h0022);

    // Randomized accesses.
    for (int i = 0; i < 300; i++) begin
      do_access(1'($urandom), 16'($urandom), 8'($urandom),
                int'($urandom_range(0, 6)), 8'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
